pe_ws_mac: RTL

- Next-generation systolic processing element: parametrised, weight-stationary multiply-accumulate cell.
- Holds a double-buffered weight, forwards subject data with valid to the neighbouring PE, and produces calc_in + weight*subject.
- Supports width-generic data, a 1- or 2-stage pipeline, wrap or saturate arithmetic, and a local-accumulate mode.
- Tiles into an N x N array; weights daisy-chain down a column, subjects travel along a row.

---
 rtl/pe_pkg.sv | 37 +++
 rtl/pe_mac_core.sv | 151 +++++++++++++++
 rtl/pe_ws_mac.sv | 125 ++++++++++++
 3 files changed

// File: rtl/pe_pkg.sv
// Shared definitions for the weight-stationary PE and the array-level adders:
// default widths, pipeline depth limit and the saturate/truncate reduction.
package pe_pkg;

  localparam int PE_DATA_W = 8;
  localparam int PE_ACC_W  = 8;
  localparam int PIPE_MAX  = 2;

  // Widest intermediate sum the reduction helper accepts.
  localparam int SUM_MAX_W = 128;

  // Reduce a wide unsigned sum to acc_w bits.
  // Returns {overflow, result}. The result occupies the low acc_w bits.
  // On overflow the result either wraps (keeps the low bits) or clamps to all-ones.
  function automatic logic [SUM_MAX_W:0] sat_trunc(
    input logic [SUM_MAX_W-1:0] sum,
    input int unsigned          acc_w,
    input logic                 saturate
  );
    logic [SUM_MAX_W-1:0] lim;
    logic [SUM_MAX_W-1:0] res;
    logic                 ovf;
    lim = {SUM_MAX_W{1'b1}} >> (SUM_MAX_W - acc_w);
    ovf = (sum > lim);
    if (ovf) begin
      if (saturate) begin
        res = lim;
      end else begin
        res = sum & lim;
      end
    end else begin
      res = sum;
    end
    return {ovf, res};
  endfunction

endpackage

// File: rtl/pe_mac_core.sv
// Multiply-add datapath of the PE: unsigned product of weight and subject,
// optional register after the multiplier, add of either calc_in or the
// accumulator, width reduction, and the registered result with its valid.
module pe_mac_core
  import pe_pkg::*;
#(
  parameter int DATA_W   = PE_DATA_W,
  parameter int ACC_W    = PE_ACC_W,
  parameter int PIPE     = 1,
  parameter int SATURATE = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic              in_mode,
  input  logic              in_clear,
  input  logic [DATA_W-1:0] in_weight,
  input  logic [DATA_W-1:0] in_subject,
  input  logic [ACC_W-1:0]  in_calc,
  input  logic [ACC_W-1:0]  acc_val,
  output logic              add_fire,
  output logic              add_mode,
  output logic              add_ovf,
  output logic [ACC_W-1:0]  add_res,
  output logic [ACC_W-1:0]  out_res,
  output logic              out_valid
);

  localparam int PROD_W = 2 * DATA_W;
  localparam int SUM_W  = ACC_W + 2 * DATA_W + 1;

  logic [PROD_W-1:0] prod_s;

  // Operands seen by the add stage (either direct or from stage 1).
  logic              a_valid_s;
  logic              a_mode_s;
  logic              a_clear_s;
  logic [PROD_W-1:0] a_prod_s;
  logic [ACC_W-1:0]  a_calc_s;

  logic [ACC_W-1:0]  addend_s;
  logic [SUM_W-1:0]  sum_s;
  logic [SUM_MAX_W:0] red_s;

  logic [ACC_W-1:0]  out_res_d, out_res_q;
  logic              out_valid_d, out_valid_q;

  // Full-width unsigned product using the weight active in the capture cycle.
  always_comb begin
    prod_s = PROD_W'(in_weight) * PROD_W'(in_subject);
  end

  if (PIPE >= PIPE_MAX) begin : g_stage1
    logic              s1_valid_d, s1_valid_q;
    logic              s1_mode_d, s1_mode_q;
    logic              s1_clear_d, s1_clear_q;
    logic [PROD_W-1:0] s1_prod_d, s1_prod_q;
    logic [ACC_W-1:0]  s1_calc_d, s1_calc_q;

    // Stage-1 next state: the sample and its mode/clear tag travel together.
    always_comb begin
      s1_valid_d = in_valid;
      s1_mode_d  = s1_mode_q;
      s1_clear_d = s1_clear_q;
      s1_prod_d  = s1_prod_q;
      s1_calc_d  = s1_calc_q;
      if (in_valid) begin
        s1_mode_d  = in_mode;
        s1_clear_d = in_clear;
        s1_prod_d  = prod_s;
        s1_calc_d  = in_calc;
      end else begin
        s1_valid_d = 1'b0;
      end
    end

    // Stage-1 register after the multiplier; reset flushes in-flight samples.
    always_ff @(posedge clk) begin
      if (reset) begin
        s1_valid_q <= 1'b0;
        s1_mode_q  <= 1'b0;
        s1_clear_q <= 1'b0;
        s1_prod_q  <= {PROD_W{1'b0}};
        s1_calc_q  <= {ACC_W{1'b0}};
      end else begin
        s1_valid_q <= s1_valid_d;
        s1_mode_q  <= s1_mode_d;
        s1_clear_q <= s1_clear_d;
        s1_prod_q  <= s1_prod_d;
        s1_calc_q  <= s1_calc_d;
      end
    end

    assign a_valid_s = s1_valid_q;
    assign a_mode_s  = s1_mode_q;
    assign a_clear_s = s1_clear_q;
    assign a_prod_s  = s1_prod_q;
    assign a_calc_s  = s1_calc_q;
  end else begin : g_direct
    assign a_valid_s = in_valid;
    assign a_mode_s  = in_mode;
    assign a_clear_s = in_clear;
    assign a_prod_s  = prod_s;
    assign a_calc_s  = in_calc;
  end

  // Add stage: a clear now, or one captured with this sample, zeroes the accumulator addend.
  always_comb begin
    addend_s = a_calc_s;
    if (a_mode_s) begin
      if (in_clear || a_clear_s) begin
        addend_s = {ACC_W{1'b0}};
      end else begin
        addend_s = acc_val;
      end
    end else begin
      addend_s = a_calc_s;
    end
    sum_s   = SUM_W'(addend_s) + SUM_W'(a_prod_s);
    red_s   = sat_trunc(SUM_MAX_W'(sum_s), unsigned'(ACC_W), (SATURATE != 0));
    add_ovf = a_valid_s & red_s[SUM_MAX_W];
    add_res = red_s[ACC_W-1:0];
  end

  // Result next state: only qualified samples change the visible result.
  always_comb begin
    out_valid_d = a_valid_s;
    if (a_valid_s) begin
      out_res_d = add_res;
    end else begin
      out_res_d = out_res_q;
    end
  end

  // Output register of the datapath.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_res_q   <= {ACC_W{1'b0}};
      out_valid_q <= 1'b0;
    end else begin
      out_res_q   <= out_res_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign add_fire  = a_valid_s;
  assign add_mode  = a_mode_s;
  assign out_res   = out_res_q;
  assign out_valid = out_valid_q;

endmodule

// File: rtl/pe_ws_mac.sv
// Weight-stationary systolic PE: double-buffered weight (shadow chained to
// the next PE, active used for compute), one-cycle subject forwarding, local
// accumulator with sticky overflow, around the pe_mac_core datapath.
module pe_ws_mac
  import pe_pkg::*;
#(
  parameter int DATA_W   = PE_DATA_W,
  parameter int ACC_W    = PE_ACC_W,
  parameter int PIPE     = 1,
  parameter int SATURATE = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] weight_in,
  input  logic              weight_load,
  input  logic              weight_swap,
  output logic [DATA_W-1:0] weight_out,
  input  logic [DATA_W-1:0] subject_in,
  input  logic              subject_valid_in,
  output logic [DATA_W-1:0] subject_out,
  output logic              subject_valid_out,
  input  logic [ACC_W-1:0]  calc_in,
  input  logic              acc_mode,
  input  logic              acc_clear,
  output logic [ACC_W-1:0]  pe_out,
  output logic              pe_valid_out,
  output logic              overflow
);

  logic [DATA_W-1:0] shadow_d, shadow_q;
  logic [DATA_W-1:0] active_d, active_q;
  logic [DATA_W-1:0] subj_d, subj_q;
  logic              subj_vld_d, subj_vld_q;
  logic [ACC_W-1:0]  acc_d, acc_q;
  logic              ovf_d, ovf_q;

  logic              add_fire_s;
  logic              add_mode_s;
  logic              add_ovf_s;
  logic [ACC_W-1:0]  add_res_s;

  pe_mac_core #(
    .DATA_W   (DATA_W),
    .ACC_W    (ACC_W),
    .PIPE     (PIPE),
    .SATURATE (SATURATE)
  ) u_core (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (subject_valid_in),
    .in_mode    (acc_mode),
    .in_clear   (acc_clear),
    .in_weight  (active_q),
    .in_subject (subject_in),
    .in_calc    (calc_in),
    .acc_val    (acc_q),
    .add_fire   (add_fire_s),
    .add_mode   (add_mode_s),
    .add_ovf    (add_ovf_s),
    .add_res    (add_res_s),
    .out_res    (pe_out),
    .out_valid  (pe_valid_out)
  );

  // Weight buffers: swap reads the old shadow even when a load lands the same cycle.
  always_comb begin
    if (weight_load) begin
      shadow_d = weight_in;
    end else begin
      shadow_d = shadow_q;
    end
    if (weight_swap) begin
      active_d = shadow_q;
    end else begin
      active_d = active_q;
    end
  end

  // Subject forwarding to the neighbour, regardless of validity.
  always_comb begin
    subj_d     = subject_in;
    subj_vld_d = subject_valid_in;
  end

  // Accumulator and sticky overflow: clear drops prior state, a firing sample still lands.
  always_comb begin
    if (add_fire_s && add_mode_s) begin
      acc_d = add_res_s;
    end else if (acc_clear) begin
      acc_d = {ACC_W{1'b0}};
    end else begin
      acc_d = acc_q;
    end
    if (acc_clear) begin
      ovf_d = add_ovf_s;
    end else begin
      ovf_d = ovf_q | add_ovf_s;
    end
  end

  // State registers of the PE wrapper.
  always_ff @(posedge clk) begin
    if (reset) begin
      shadow_q   <= {DATA_W{1'b0}};
      active_q   <= {DATA_W{1'b0}};
      subj_q     <= {DATA_W{1'b0}};
      subj_vld_q <= 1'b0;
      acc_q      <= {ACC_W{1'b0}};
      ovf_q      <= 1'b0;
    end else begin
      shadow_q   <= shadow_d;
      active_q   <= active_d;
      subj_q     <= subj_d;
      subj_vld_q <= subj_vld_d;
      acc_q      <= acc_d;
      ovf_q      <= ovf_d;
    end
  end

  assign weight_out        = shadow_q;
  assign subject_out       = subj_q;
  assign subject_valid_out = subj_vld_q;
  assign overflow          = ovf_q;

endmodule
